fft_pair_buffer: RTL and testbench
==================================

// Module: fft_pair_buffer
// PURPOSE
// Upstream feeder for the first radix-2 butterfly stage. Takes a frame streamed as LANES complex
// samples per valid beat and stores the first half-frame (HALF_DEPTH beats). During the second
// half it presents each stored beat (port a) alongside the matching new beat (port b), so sample
// n is paired with sample n + LANES*HALF_DEPTH. The butterfly consumes a/b directly.
// PARAMETERS
// LANES       16  complex samples per beat
// DATA_W      15  signed width of each real/imag sample
// HALF_DEPTH  16  beats per half-frame (frame = 2*HALF_DEPTH beats)
// IDX_W       $clog2(HALF_DEPTH)  width of pair_idx (derived, not overridden)
// PORTS
// clk          in   1                      rising-edge clock
// rst          in   1                      asynchronous reset, active-high
// clr          in   1                      sync abort: drop partial frame, return to FILL
// valid_in     in   1                      din_* holds a beat this cycle
// din_real     in   DATA_W x LANES signed  real parts of incoming beat
// din_imag     in   DATA_W x LANES signed  imag parts of incoming beat
// valid_out    out  1                      dout_* holds a valid pair
// dout_real_a  out  DATA_W x LANES signed  stored first-half beat, real
// dout_imag_a  out  DATA_W x LANES signed  stored first-half beat, imag
// dout_real_b  out  DATA_W x LANES signed  current second-half beat, real
// dout_imag_b  out  DATA_W x LANES signed  current second-half beat, imag
// pair_idx     out  IDX_W                  beat index within half-frame of the output pair
// frame_done   out  1                      1-cycle pulse with the last pair of a frame
// BEHAVIOUR
// - Single clock domain; rst is asynchronous, active-high. All outputs are registered.
// - Reset values: valid_out=0, frame_done=0, pair_idx=0, all dout_*=0, state=FILL, cnt=0.
//   Buffer storage is not reset; it is never read before being written in the current frame.
// - State FILL: each valid_in beat writes din_* to buf[cnt] and increments cnt.
//   When cnt=HALF_DEPTH-1 and valid_in=1, cnt wraps to 0 and state moves to PAIR.
//   valid_out stays 0 in FILL.
// - State PAIR: on each valid_in beat, next cycle (latency 1):
//   valid_out=1; dout_*_a=buf[cnt]; dout_*_b=din_*; pair_idx=cnt.
//   When cnt=HALF_DEPTH-1 with valid_in=1: frame_done=1 in the same output cycle, cnt wraps
//   to 0, state moves back to FILL.
// - Back-to-back frames: a beat arriving the cycle after the last PAIR beat is written to buf[0]
//   as FILL data with no bubble. Reads in PAIR complete before any FILL rewrite of that entry.
// - Gaps: with valid_in=0, cnt and state hold; next cycle valid_out=0 and frame_done=0.
//   dout_* and pair_idx keep their last value.
// - clr: synchronous, priority over valid_in. cnt=0, state=FILL, valid_out=0, frame_done=0.
//   A beat coincident with clr is dropped. dout_* hold their last value.
// - rst asserted mid-frame: immediate return to reset values. The partial frame is discarded.
// - Data path is pass-through: no arithmetic, no width change, sign preserved bit-exact.
// - No backpressure: the consumer accepts every valid_out beat.
// TESTING
// 1 Reset: assert rst mid-stream -> valid_out, frame_done, pair_idx, dout_* read 0 the same
//   cycle (async); state FILL after release.
// 2 Single frame, 32 consecutive beats, lane k of beat j real=j*16+k, imag=-(j*16+k):
//   beats 0-15 give valid_out=0. Beats 16-31 give valid_out=1 one cycle later, with
//   real_a=(j-16)*16+k, real_b=j*16+k, pair_idx=j-16. frame_done=1 only with pair_idx=15.
// 3 Back-to-back: two frames, 64 beats, no gaps -> 32 valid pairs, frame_done twice.
//   Second frame's pairs use only second-frame data.
// 4 Gaps: insert valid_in=0 every third cycle in frame of test 2 -> identical pair sequence.
//   valid_out=0 on gap-following cycles; dout_* held.
// 5 Abort: clr with valid_in=1 at beat 10 of FILL, then a fresh 32-beat frame -> first pair
//   a=fresh beat 0, b=fresh beat 16. The dropped beat never appears.
// 6 Extremes: all lanes real=-16384, imag=16383 in first half; opposite in second half ->
//   a/b outputs bit-exact, no sign corruption.

Source files
------------

// File: rtl/fft_pair_buffer_if.sv
// rtl/fft_pair_buffer_if.sv - beat stream in / butterfly pair stream out bundle
//
// Purpose: groups the incoming beat stream and the outgoing a/b pair stream
// of fft_pair_buffer so the producer side and the buffer share one handle.
// Signals:
//   valid_in             beat present on din_* this cycle
//   din_real, din_imag   LANES x DATA_W signed samples of the incoming beat
//   valid_out            dout_* hold a valid pair
//   dout_real_a/imag_a   stored first-half beat
//   dout_real_b/imag_b   matching second-half beat
//   pair_idx             beat index within the half-frame of the output pair
//   frame_done           pulse alongside the last pair of a frame
// Modports: master = beat producer / pair consumer, slave = the buffer.
`timescale 1ns/1ps

interface fft_pair_buffer_if #(
  parameter int LANES      = 16,
  parameter int DATA_W     = 15,
  parameter int HALF_DEPTH = 16
);
  localparam int IDX_W = $clog2(HALF_DEPTH);

  logic                                valid_in;
  logic signed [LANES-1:0][DATA_W-1:0] din_real;
  logic signed [LANES-1:0][DATA_W-1:0] din_imag;

  logic                                valid_out;
  logic signed [LANES-1:0][DATA_W-1:0] dout_real_a;
  logic signed [LANES-1:0][DATA_W-1:0] dout_imag_a;
  logic signed [LANES-1:0][DATA_W-1:0] dout_real_b;
  logic signed [LANES-1:0][DATA_W-1:0] dout_imag_b;
  logic        [IDX_W-1:0]             pair_idx;
  logic                                frame_done;

  modport master (
    output valid_in, din_real, din_imag,
    input  valid_out, dout_real_a, dout_imag_a, dout_real_b, dout_imag_b,
           pair_idx, frame_done
  );

  modport slave (
    input  valid_in, din_real, din_imag,
    output valid_out, dout_real_a, dout_imag_a, dout_real_b, dout_imag_b,
           pair_idx, frame_done
  );
endinterface

// File: rtl/fft_pair_buffer.sv
// rtl/fft_pair_buffer.sv - half-frame buffer pairing sample n with n+LANES*HALF_DEPTH
//
// Purpose: feeds the first radix-2 butterfly stage. The first HALF_DEPTH beats
// of a frame are stored; each of the next HALF_DEPTH beats is emitted next to
// the stored beat with the same index.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   clr   synchronous abort: partial frame dropped, back to FILL
//   bus   fft_pair_buffer_if slave (beat stream in, pair stream out)
`timescale 1ns/1ps

module fft_pair_buffer #(
  parameter int LANES      = 16,
  parameter int DATA_W     = 15,
  parameter int HALF_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  fft_pair_buffer_if.slave  bus
);
  localparam int IDX_W = $clog2(HALF_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF_DEPTH - 1);

  typedef logic signed [LANES-1:0][DATA_W-1:0] beat_t;
  typedef enum logic {FILL, PAIR} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  // Storage is deliberately unreset: every entry is rewritten in FILL before
  // PAIR reads it.
  beat_t mem_re [HALF_DEPTH];
  beat_t mem_im [HALF_DEPTH];

  logic beat_ok;
  assign beat_ok = bus.valid_in && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr) begin
      state_nxt = FILL;
      cnt_nxt   = '0;
    end else if (bus.valid_in) begin
      if (cnt == LAST_IDX) begin
        cnt_nxt   = '0;
        state_nxt = (state == FILL) ? PAIR : FILL;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok && state == FILL) begin
      mem_re[cnt] <= bus.din_real;
      mem_im[cnt] <= bus.din_imag;
    end
  end

  // The PAIR read of mem[cnt] lands in the output register on the same edge
  // that leaves PAIR, so a back-to-back FILL rewrite of entry 0 is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out   <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.pair_idx    <= '0;
      bus.dout_real_a <= '0;
      bus.dout_imag_a <= '0;
      bus.dout_real_b <= '0;
      bus.dout_imag_b <= '0;
    end else if (beat_ok && state == PAIR) begin
      bus.valid_out   <= 1'b1;
      bus.frame_done  <= (cnt == LAST_IDX);
      bus.pair_idx    <= cnt;
      bus.dout_real_a <= mem_re[cnt];
      bus.dout_imag_a <= mem_im[cnt];
      bus.dout_real_b <= bus.din_real;
      bus.dout_imag_b <= bus.din_imag;
    end else begin
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fft_pair_buffer.sv
// tb/tb_fft_pair_buffer.sv - directed bench for fft_pair_buffer
`timescale 1ns/1ps

module tb_fft_pair_buffer;
  localparam int LANES      = 16;
  localparam int DATA_W     = 15;
  localparam int HALF_DEPTH = 16;

  typedef logic signed [LANES-1:0][DATA_W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fft_pair_buffer_if #(.LANES(LANES), .DATA_W(DATA_W), .HALF_DEPTH(HALF_DEPTH)) bus ();

  fft_pair_buffer #(.LANES(LANES), .DATA_W(DATA_W), .HALF_DEPTH(HALF_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk_re(input int idx);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = DATA_W'(idx * 16 + k);
    return v;
  endfunction

  function automatic vec_t mk_im(input int idx);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = DATA_W'(-(idx * 16 + k));
    return v;
  endfunction

  function automatic vec_t mk_const(input int val);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = DATA_W'(val);
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_vec(input vec_t re, input vec_t im);
    bus.valid_in = 1'b1;
    bus.din_real = re;
    bus.din_imag = im;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx);
    send_vec(mk_re(idx), mk_im(idx));
  endtask

  task automatic gap();
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair_vec(input string tag, input vec_t ar, input vec_t ai,
                                input vec_t br, input vec_t bi, input int pidx, input bit fd);
    check({tag, ".valid_out"},  bus.valid_out, 1);
    check({tag, ".real_a"},     bus.dout_real_a, ar);
    check({tag, ".imag_a"},     bus.dout_imag_a, ai);
    check({tag, ".real_b"},     bus.dout_real_b, br);
    check({tag, ".imag_b"},     bus.dout_imag_b, bi);
    check({tag, ".pair_idx"},   bus.pair_idx, pidx);
    check({tag, ".frame_done"}, bus.frame_done, fd);
  endtask

  task automatic check_pair(input string tag, input int a_idx, input int b_idx,
                            input int pidx, input bit fd);
    check_pair_vec(tag, mk_re(a_idx), mk_im(a_idx), mk_re(b_idx), mk_im(b_idx), pidx, fd);
  endtask

  task automatic check_idle_out(input string tag);
    check({tag, ".valid_out"},  bus.valid_out, 0);
    check({tag, ".frame_done"}, bus.frame_done, 0);
  endtask

  initial begin
    int pairs;
    int fds;
    int j;
    int c;
    int last;

    bus.valid_in = 1'b0;
    bus.din_real = '0;
    bus.din_imag = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid_out",  bus.valid_out, 0);
    check("rst.frame_done", bus.frame_done, 0);
    check("rst.pair_idx",   bus.pair_idx, 0);
    check("rst.real_a",     bus.dout_real_a, 0);
    check("rst.real_b",     bus.dout_real_b, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // async reset mid-stream, applied between clock edges
    for (int i = 0; i < 20; i++) send(i);
    check("midrst.pre_valid", bus.valid_out, 1);
    bus.valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst.valid_out",  bus.valid_out, 0);
    check("midrst.frame_done", bus.frame_done, 0);
    check("midrst.pair_idx",   bus.pair_idx, 0);
    check("midrst.real_a",     bus.dout_real_a, 0);
    check("midrst.imag_a",     bus.dout_imag_a, 0);
    check("midrst.real_b",     bus.dout_real_b, 0);
    check("midrst.imag_b",     bus.dout_imag_b, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single frame, 32 consecutive beats
    for (int i = 0; i < 32; i++) begin
      send(i);
      if (i < 16) check($sformatf("single.fill%0d.valid_out", i), bus.valid_out, 0);
      else check_pair($sformatf("single.b%0d", i), i - 16, i, i - 16, i == 31);
    end
    gap();
    check_idle_out("single.after");
    check("single.after.real_b_hold", bus.dout_real_b, mk_re(31));
    check("single.after.pair_idx_hold", bus.pair_idx, 15);

    // back-to-back frames, 64 beats with no gap
    pairs = 0;
    fds = 0;
    for (int i = 0; i < 64; i++) begin
      send(i);
      if (bus.valid_out) pairs++;
      if (bus.frame_done) fds++;
      if (i % 32 >= 16) check_pair($sformatf("b2b.b%0d", i), i - 16, i, i % 32 - 16, i % 32 == 31);
      else check($sformatf("b2b.fill%0d.valid_out", i), bus.valid_out, 0);
    end
    check("b2b.pair_count", pairs, 32);
    check("b2b.frame_done_count", fds, 2);

    // gaps every third cycle
    j = 0;
    c = 0;
    last = -1;
    while (j < 32) begin
      if (c % 3 == 2) begin
        gap();
        check_idle_out($sformatf("gap.c%0d", c));
        if (last >= 0) begin
          check($sformatf("gap.c%0d.real_a_hold", c), bus.dout_real_a, mk_re(last - 16));
          check($sformatf("gap.c%0d.real_b_hold", c), bus.dout_real_b, mk_re(last));
        end
      end else begin
        send(200 + j);
        if (j < 16) check($sformatf("gap.fill%0d.valid_out", j), bus.valid_out, 0);
        else begin
          check_pair($sformatf("gap.b%0d", j), 200 + j - 16, 200 + j, j - 16, j == 31);
          last = 200 + j;
        end
        j++;
      end
      c++;
    end

    // abort with clr at FILL beat 10, then a fresh frame
    for (int i = 0; i < 10; i++) send(300 + i);
    clr = 1'b1;
    send(500);
    clr = 1'b0;
    check_idle_out("abort.clr_cycle");
    for (int i = 0; i < 32; i++) begin
      send(600 + i);
      if (i < 16) check($sformatf("abort.fill%0d.valid_out", i), bus.valid_out, 0);
      else check_pair($sformatf("abort.b%0d", i), 600 + i - 16, 600 + i, i - 16, i == 31);
    end

    // extreme values
    for (int i = 0; i < 16; i++) send_vec(mk_const(-16384), mk_const(16383));
    for (int i = 0; i < 16; i++) begin
      send_vec(mk_const(16383), mk_const(-16384));
      check_pair_vec($sformatf("ext.b%0d", i), mk_const(-16384), mk_const(16383),
                     mk_const(16383), mk_const(-16384), i, i == 15);
    end
    check("ext.lane0_real_a_raw", bus.dout_real_a[0], 15'h4000);
    check("ext.lane0_real_b_raw", bus.dout_real_b[0], 15'h3fff);
    gap();
    check_idle_out("ext.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
